// File: rtl/sys_bridge_pkg.sv
// ============================================================================
// Module      : sys_bridge_pkg
// Description : Shared types and helpers for the sys_bridge_n Pr-bus bridge:
//               FSM state encoding, access classification, control-window
//               register offsets and the control-window decode function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sys_bridge_pkg;

    // Bridge access sequencer states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Classification of the request latched in IDLE
    typedef enum logic [1:0] {
        K_MISS = 2'd0,
        K_DEV  = 2'd1,
        K_CTL  = 2'd2
    } kind_t;

    // Word offsets inside the 16-byte control window
    localparam logic [1:0]  CTL_OFF_MASK  = 2'd0;
    localparam logic [1:0]  CTL_OFF_PEND  = 2'd1;
    localparam logic [1:0]  CTL_OFF_ID    = 2'd2;
    localparam logic [31:0] CTL_WIN_BYTES = 32'd16;

    // True when addr falls in the 16-byte control window starting at ctl_base
    function automatic logic ctl_hit(input logic [31:0] addr, input logic [31:0] ctl_base);
        logic [31:0] diff;
        diff = addr - ctl_base;
        return (addr >= ctl_base) && (diff < CTL_WIN_BYTES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_prio_enc.sv
// ============================================================================
// Module      : irq_prio_enc
// Description : Device interrupt synchroniser, masked pending register and
//               lowest-index-wins priority encoder.
//               Macro SYS_BRIDGE_IRQ_SYNC2_EN selects a two-flop synchroniser
//               for asynchronous sources; otherwise a single register stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc #(
    parameter int N_DEV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] irq,
    input  logic [N_DEV-1:0] mask,
    output logic [N_DEV-1:0] pend,
    output logic             int_req,
    output logic [3:0]       int_id
);

    logic [N_DEV-1:0] irq_s;

`ifdef SYS_BRIDGE_IRQ_SYNC2_EN
    logic [N_DEV-1:0] irq_meta;

    // Two-stage synchroniser for asynchronous interrupt sources
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_meta <= '0;
            irq_s    <= '0;
        end else begin
            irq_meta <= irq;
            irq_s    <= irq_meta;
        end
    end
`else
    // Single register stage for interrupt lines already in this clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_s <= '0;
        end else begin
            irq_s <= irq;
        end
    end
`endif

    // Masked pending set, registered so int_req/int_id are glitch-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            pend <= irq_s & mask;
        end
    end

    assign int_req = |pend;

    // Lowest-numbered pending device wins; scan from the top so index 0 ends last
    always_comb begin
        int_id = 4'd0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (pend[i]) begin
                int_id = 4'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sys_bridge_n.sv
// ============================================================================
// Module      : sys_bridge_n
// Description : Pr-bus to N_DEV device bridge. Decodes device windows and a
//               local control window (MASK/PEND/ID), sequences strobes with
//               WAIT_CYC read wait states, returns registered read data and
//               aggregates masked device interrupts for CP0.
//               Optional macro: SYS_BRIDGE_IRQ_SYNC2_EN (two-flop irq sync).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sys_bridge_n
    import sys_bridge_pkg::*;
#(
    parameter int          N_DEV     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          WIN_BITS  = 4,
    parameter int          WAIT_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pr_addr,
    input  logic [31:0]           pr_wdata,
    input  logic                  pr_we,
    input  logic                  pr_re,
    output logic [31:0]           pr_rdata,
    output logic                  pr_ready,
    output logic                  pr_err,
    output logic [N_DEV-1:0]      dev_sel,
    output logic [WIN_BITS-3:0]   dev_addr,
    output logic [31:0]           dev_wdata,
    output logic                  dev_we,
    output logic                  dev_re,
    input  logic [32*N_DEV-1:0]   dev_rdata,
    input  logic [N_DEV-1:0]      dev_irq,
    output logic                  int_req,
    output logic [3:0]            int_id
);

    localparam int          IDX_W     = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam logic [31:0] DEV_SPAN  = 32'(N_DEV) << WIN_BITS;
    localparam logic [31:0] CTL_BASE  = BASE_ADDR + DEV_SPAN;
    localparam logic [2:0]  WAIT_LAST = 3'(WAIT_CYC - 1);

    state_t             state;
    kind_t              kind;
    logic               is_write;
    logic [IDX_W-1:0]   dev_idx;
    logic [1:0]         ctl_off;
    logic [N_DEV-1:0]   wmask;
    logic [2:0]         wait_cnt;
    logic [N_DEV-1:0]   mask;
    logic [N_DEV-1:0]   pend;

    logic [31:0]        dev_off;
    logic               dev_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic [N_DEV-1:0]   dec_sel;
    logic [1:0]         dec_ctl_off;
    logic [31:0]        ctl_rdata;
    logic [31:0]        rd_arr [N_DEV];

    // Split the concatenated device read buses into an indexable array
    genvar g;
    generate
        for (g = 0; g < N_DEV; g++) begin : g_rd
            assign rd_arr[g] = dev_rdata[32*g +: 32];
        end
    endgenerate

    assign dev_off     = pr_addr - BASE_ADDR;
    assign dev_hit     = (pr_addr >= BASE_ADDR) && (dev_off < DEV_SPAN);
    assign dec_idx     = dev_off[WIN_BITS +: IDX_W];
    // Low address bits are enough for the offset: the window is 16 bytes long
    assign dec_ctl_off = 2'(pr_addr[3:2] - CTL_BASE[3:2]);

    // One-hot select for the decoded device index
    always_comb begin
        dec_sel          = '0;
        dec_sel[dec_idx] = 1'b1;
    end

    // Control-window read mux; offset 12 reads as zero
    always_comb begin
        ctl_rdata = 32'd0;
        case (ctl_off)
            CTL_OFF_MASK: ctl_rdata = 32'(mask);
            CTL_OFF_PEND: ctl_rdata = 32'(pend);
            CTL_OFF_ID:   ctl_rdata = 32'(int_id);
            default:      ctl_rdata = 32'd0;
        endcase
    end

    // Access sequencer with registered bus and device-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            kind      <= K_MISS;
            is_write  <= 1'b0;
            dev_idx   <= '0;
            ctl_off   <= 2'd0;
            wmask     <= '0;
            wait_cnt  <= 3'd0;
            mask      <= '0;
            pr_rdata  <= 32'd0;
            pr_ready  <= 1'b0;
            pr_err    <= 1'b0;
            dev_sel   <= '0;
            dev_addr  <= '0;
            dev_wdata <= 32'd0;
            dev_we    <= 1'b0;
            dev_re    <= 1'b0;
        end else begin
            dev_we   <= 1'b0;
            dev_re   <= 1'b0;
            pr_ready <= 1'b0;
            pr_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pr_we || pr_re) begin
                        state    <= S_ACCESS;
                        pr_rdata <= 32'd0;
                        is_write <= pr_we;
                        wmask    <= pr_wdata[N_DEV-1:0];
                        ctl_off  <= dec_ctl_off;
                        if (pr_we && pr_re) begin
                            kind <= K_MISS;
                        end else if (dev_hit) begin
                            kind      <= K_DEV;
                            dev_idx   <= dec_idx;
                            dev_sel   <= dec_sel;
                            dev_addr  <= dev_off[WIN_BITS-1:2];
                            dev_wdata <= pr_wdata;
                            dev_we    <= pr_we;
                            dev_re    <= pr_re;
                        end else if (ctl_hit(pr_addr, CTL_BASE)) begin
                            kind <= K_CTL;
                        end else begin
                            kind <= K_MISS;
                        end
                    end
                end
                S_ACCESS: begin
                    wait_cnt <= 3'd0;
                    if ((kind == K_DEV) && !is_write && (WAIT_CYC != 0)) begin
                        state <= S_WAIT;
                    end else begin
                        state    <= S_DONE;
                        pr_ready <= 1'b1;
                        pr_err   <= (kind == K_MISS);
                        dev_sel  <= '0;
                        if (!is_write && (kind == K_DEV)) begin
                            pr_rdata <= rd_arr[dev_idx];
                        end
                        if (!is_write && (kind == K_CTL)) begin
                            pr_rdata <= ctl_rdata;
                        end
                        if (is_write && (kind == K_CTL) && (ctl_off == CTL_OFF_MASK)) begin
                            mask <= wmask;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state    <= S_DONE;
                        pr_ready <= 1'b1;
                        pr_rdata <= rd_arr[dev_idx];
                        dev_sel  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    irq_prio_enc #(
        .N_DEV (N_DEV)
    ) u_irq (
        .clk     (clk),
        .rst     (rst),
        .irq     (dev_irq),
        .mask    (mask),
        .pend    (pend),
        .int_req (int_req),
        .int_id  (int_id)
    );

endmodule

`default_nettype wire

// File: tb/tb_sys_bridge_n.sv
// ============================================================================
// Module      : tb_sys_bridge_n
// Description : Scoreboard bench for sys_bridge_n (N_DEV=4, WIN_BITS=4,
//               WAIT_CYC=2). Directed accesses push expected responses and
//               strobes; independent monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sys_bridge_n;

    localparam int N_DEV    = 4;
    localparam int WIN_BITS = 4;
    localparam int WAIT_CYC = 2;
`ifdef SYS_BRIDGE_IRQ_SYNC2_EN
    localparam int IRQ_LAT  = 3;
`else
    localparam int IRQ_LAT  = 2;
`endif

    logic                clk;
    logic                rst;
    logic [31:0]         pr_addr;
    logic [31:0]         pr_wdata;
    logic                pr_we;
    logic                pr_re;
    logic [31:0]         pr_rdata;
    logic                pr_ready;
    logic                pr_err;
    logic [N_DEV-1:0]    dev_sel;
    logic [WIN_BITS-3:0] dev_addr;
    logic [31:0]         dev_wdata;
    logic                dev_we;
    logic                dev_re;
    logic [32*N_DEV-1:0] dev_rdata;
    logic [N_DEV-1:0]    dev_irq;
    logic                int_req;
    logic [3:0]          int_id;

    sys_bridge_n #(
        .N_DEV     (N_DEV),
        .BASE_ADDR (32'h0000_7F00),
        .WIN_BITS  (WIN_BITS),
        .WAIT_CYC  (WAIT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pr_addr   (pr_addr),
        .pr_wdata  (pr_wdata),
        .pr_we     (pr_we),
        .pr_re     (pr_re),
        .pr_rdata  (pr_rdata),
        .pr_ready  (pr_ready),
        .pr_err    (pr_err),
        .dev_sel   (dev_sel),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_we    (dev_we),
        .dev_re    (dev_re),
        .dev_rdata (dev_rdata),
        .dev_irq   (dev_irq),
        .int_req   (int_req),
        .int_id    (int_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [3:0]  sel;
        logic [1:0]  addr;
        logic        we;
        logic        re;
        logic [31:0] wd;
        int          cyc;
    } stb_t;

    rsp_t rsp_q[$];
    stb_t stb_q[$];

    // Response monitor: every pr_ready pulse must match the oldest expectation
    always @(negedge clk) begin
        rsp_t e;
        if (rst && pr_ready) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got rdata=%h err=%b cyc=%0d", pr_rdata, pr_err, cyc);
            end else begin
                e = rsp_q.pop_front();
                if (pr_rdata !== e.rd || pr_err !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rsp got rdata=%h err=%b cyc=%0d want rdata=%h err=%b cyc=%0d",
                             pr_rdata, pr_err, cyc, e.rd, e.err, e.cyc);
                end
            end
        end
    end

    // Strobe monitor: every dev_we/dev_re cycle must match an expected strobe
    always @(negedge clk) begin
        stb_t s;
        if (rst && (dev_we || dev_re)) begin
            checks++;
            if (stb_q.size() == 0) begin
                errors++;
                $display("FAIL stb_unexpected got sel=%b we=%b re=%b cyc=%0d", dev_sel, dev_we, dev_re, cyc);
            end else begin
                s = stb_q.pop_front();
                if (dev_sel !== s.sel || dev_addr !== s.addr || dev_we !== s.we || dev_re !== s.re ||
                    cyc != s.cyc || (s.we && dev_wdata !== s.wd)) begin
                    errors++;
                    $display("FAIL stb got sel=%b addr=%0d we=%b re=%b wd=%h cyc=%0d want sel=%b addr=%0d we=%b re=%b wd=%h cyc=%0d",
                             dev_sel, dev_addr, dev_we, dev_re, dev_wdata, cyc,
                             s.sel, s.addr, s.we, s.re, s.wd, s.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    // One complete Pr-bus access; returns at the negedge where pr_ready is seen
    task automatic do_acc(input logic [31:0] a, input logic [31:0] wd, input logic we, input logic re,
                          input logic [31:0] erd, input logic eerr, input int lat,
                          input logic stb, input logic [3:0] esel, input logic [1:0] eaddr);
        int c0;
        bit seen;
        @(negedge clk);
        pr_addr  = a;
        pr_wdata = wd;
        pr_we    = we;
        pr_re    = re;
        c0       = cyc;
        rsp_q.push_back('{erd, eerr, c0 + lat});
        if (stb) stb_q.push_back('{esel, eaddr, we, re, wd, c0 + 1});
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = pr_ready;
        end
        pr_we = 1'b0;
        pr_re = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%h got no pr_ready want pr_ready", a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst       = 1'b0;
        pr_addr   = 32'd0;
        pr_wdata  = 32'd0;
        pr_we     = 1'b0;
        pr_re     = 1'b0;
        dev_irq   = '0;
        dev_rdata = {32'h1234_5678, 32'h2222_0002, 32'h1111_0001, 32'h0BAD_0000};

        // Reset state
        #3;
        chk("rst_pr_rdata", pr_rdata, 32'd0);
        chk("rst_pr_ready", 32'(pr_ready), 32'd0);
        chk("rst_pr_err", 32'(pr_err), 32'd0);
        chk("rst_dev_sel", 32'(dev_sel), 32'd0);
        chk("rst_dev_addr", 32'(dev_addr), 32'd0);
        chk("rst_dev_wdata", dev_wdata, 32'd0);
        chk("rst_strobes", {30'd0, dev_we, dev_re}, 32'd0);
        chk("rst_int", {27'd0, int_req, int_id}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Device accesses
        do_acc(32'h7F14, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0, 1'b0, 2, 1'b1, 4'b0010, 2'd1);
        do_acc(32'h7F30, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 2 + WAIT_CYC, 1'b1, 4'b1000, 2'd0);
        do_acc(32'h7F18, 32'd0, 1'b0, 1'b1, 32'h1111_0001, 1'b0, 2 + WAIT_CYC, 1'b1, 4'b0010, 2'd2);
        do_acc(32'h7F3C, 32'd0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 2 + WAIT_CYC, 1'b1, 4'b1000, 2'd3);
        do_acc(32'h7F00, 32'hCAFE_0000, 1'b1, 1'b0, 32'd0, 1'b0, 2, 1'b1, 4'b0001, 2'd0);

        // Misses: outside windows, just below base, just past control window, we&re together
        do_acc(32'h8000, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 2, 1'b0, 4'b0000, 2'd0);
        do_acc(32'h7EFC, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 2, 1'b0, 4'b0000, 2'd0);
        do_acc(32'h7F50, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 2, 1'b0, 4'b0000, 2'd0);
        do_acc(32'h7F14, 32'h55AA_55AA, 1'b1, 1'b1, 32'd0, 1'b1, 2, 1'b0, 4'b0000, 2'd0);

        // Control window and interrupts
        do_acc(32'h7F40, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 2, 1'b0, 4'b0000, 2'd0);
        do_acc(32'h7F40, 32'hFFFF_FFFA, 1'b1, 1'b0, 32'd0, 1'b0, 2, 1'b0, 4'b0000, 2'd0);
        @(negedge clk);
        dev_irq = 4'b1110;
        for (int k = 1; k < IRQ_LAT; k++) begin
            @(negedge clk);
            chk("irq_latency_low", 32'(int_req), 32'd0);
        end
        @(negedge clk);
        chk("irq_req", 32'(int_req), 32'd1);
        chk("irq_id", 32'(int_id), 32'd1);
        do_acc(32'h7F44, 32'd0, 1'b0, 1'b1, 32'h0000_000A, 1'b0, 2, 1'b0, 4'b0000, 2'd0);
        do_acc(32'h7F48, 32'd0, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 2, 1'b0, 4'b0000, 2'd0);
        do_acc(32'h7F4C, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 1'b0, 2, 1'b0, 4'b0000, 2'd0);
        do_acc(32'h7F4C, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 2, 1'b0, 4'b0000, 2'd0);
        do_acc(32'h7F40, 32'd0, 1'b0, 1'b1, 32'h0000_000A, 1'b0, 2, 1'b0, 4'b0000, 2'd0);

        // MASK update reaches pend only the cycle after DONE
        do_acc(32'h7F40, 32'h0000_0008, 1'b1, 1'b0, 32'd0, 1'b0, 2, 1'b0, 4'b0000, 2'd0);
        chk("mask_done_cycle_id", 32'(int_id), 32'd1);
        @(negedge clk);
        chk("mask_after_done_id", 32'(int_id), 32'd3);
        chk("mask_after_done_req", 32'(int_req), 32'd1);

        // Reset asserted during WAIT of a device read
        @(negedge clk);
        pr_addr = 32'h7F34;
        pr_re   = 1'b1;
        c0      = cyc;
        stb_q.push_back('{4'b1000, 2'd1, 1'b0, 1'b1, pr_wdata, c0 + 1});
        @(negedge clk);
        @(negedge clk);
        chk("wait_sel_held", 32'(dev_sel), 32'h8);
        chk("wait_re_low", 32'(dev_re), 32'd0);
        chk("wait_int_req", 32'(int_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_sel", 32'(dev_sel), 32'd0);
        chk("arst_strobes", {30'd0, dev_we, dev_re}, 32'd0);
        chk("arst_ready", 32'(pr_ready), 32'd0);
        chk("arst_int_req", 32'(int_req), 32'd0);
        pr_re = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Back in IDLE with MASK cleared; a fresh access completes normally
        do_acc(32'h7F40, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 2, 1'b0, 4'b0000, 2'd0);
        do_acc(32'h7F24, 32'h0123_4567, 1'b1, 1'b0, 32'd0, 1'b0, 2, 1'b1, 4'b0100, 2'd1);
        repeat (3) @(negedge clk);
        chk("post_rst_int_req", 32'(int_req), 32'd0);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        chk("stb_queue_empty", 32'(stb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sys_bridge_n.md
# sys_bridge_n

Parametrised processor-to-device bridge with integrated interrupt aggregation: successor to the fixed single-device Pr-bus path of the multicycle CPU. Decodes the CPU's Pr-bus address into one of `N_DEV` device windows, runs a handshake with per-access wait states, returns registered read data, and merges masked device interrupt lines into a single prioritised `int_req`/`int_id` pair for the CP0 block. Sits between the CPU top and the device set.

## Interface
Parameters:
- `N_DEV`, 4: number of device windows (1..16)
- `BASE_ADDR`, 32'h0000_7F00: byte address of device 0 window
- `WIN_BITS`, 4: log2 window size in bytes (each device gets `2**WIN_BITS` bytes)
- `WAIT_CYC`, 1: extra cycles between `dev_re` and read-data capture (0..7)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `pr_addr`  in  32  CPU byte address, held until `pr_ready`
- `pr_wdata`  in  32  CPU write data
- `pr_we`  in  1  write request, level, held until `pr_ready`
- `pr_re`  in  1  read request, level, held until `pr_ready`
- `pr_rdata`  out  32  registered read data, valid while `pr_ready`=1
- `pr_ready`  out  1  single-cycle completion pulse
- `pr_err`  out  1  decode error, valid with `pr_ready`
- `dev_sel`  out  N_DEV  one-hot device select
- `dev_addr`  out  WIN_BITS-2  word offset inside window
- `dev_wdata`  out  32  write data to devices
- `dev_we`  out  1  device write strobe
- `dev_re`  out  1  device read strobe
- `dev_rdata`  in  32*N_DEV  concatenated device read buses, device i at [32i+31:32i]
- `dev_irq`  in  N_DEV  level device interrupt lines
- `int_req`  out  1  aggregated interrupt request to CP0
- `int_id`  out  4  index of lowest-numbered pending device

## Operation
- FSM states IDLE, ACCESS, WAIT, DONE. Reset state IDLE.
- IDLE: sample `pr_we`/`pr_re`. Decode: `pr_addr` in `[BASE_ADDR, BASE_ADDR + N_DEV<<WIN_BITS)` → device hit; control window at `BASE_ADDR + N_DEV<<WIN_BITS` (16 bytes) → local hit; else miss. Go ACCESS.
- `pr_we` and `pr_re` both high → treated as miss.
- ACCESS: hit drives `dev_sel`, `dev_addr`, `dev_wdata`, and `dev_we` or `dev_re` for exactly this cycle. Write → DONE. Read → WAIT if `WAIT_CYC`>0, else DONE with capture.
- WAIT: counter counts `WAIT_CYC` cycles, `dev_sel` held, `dev_re` low; capture selected `dev_rdata` on last cycle, → DONE.
- DONE: `pr_ready`=1 one cycle; `pr_rdata` holds captured value (0 on miss or write); `pr_err`=1 on miss. → IDLE.
- Control window (local): offset 0 MASK (RW, N_DEV bits, reset 0), offset 4 PEND (RO, `irq_s & MASK`), offset 8 ID (RO, `int_id`), offset 12 reads 0, writes ignored. Local reads take no wait states.
- Interrupts: `irq_s` = synchronised `dev_irq`. `pend = irq_s & MASK` registered; `int_req = |pend`; `int_id` = lowest set index of `pend`, 0 when none. Level semantics; clearing is the device's job.
- MASK write takes effect on `pend` the cycle after DONE.

## Timing
- Reset values: `pr_rdata`=0, `pr_ready`=0, `pr_err`=0, `dev_sel`=0, `dev_addr`=0, `dev_wdata`=0, `dev_we`=0, `dev_re`=0, `int_req`=0, `int_id`=0, MASK=0, sync flops 0.
- Write: request seen cycle T → strobe T+1 → `pr_ready` T+2.
- Read: strobe T+1, capture end of T+1+`WAIT_CYC`, `pr_ready` T+2+`WAIT_CYC`.
- Next request accepted earliest cycle after DONE.
- `rst` low mid-access: all strobes and `pr_ready` drop immediately (async); no partial completion.
- Interrupt latency `dev_irq` → `int_req`: 2 cycles (1 sync + pend reg), 3 with sync macro.

## Configuration
- `SYS_BRIDGE_IRQ_SYNC2_EN` defined: `dev_irq` passes a two-flop synchroniser before masking (asynchronous device sources). Undefined: single register stage. Only interrupt latency changes.

## Structure
- Package `sys_bridge_pkg`: FSM state enum, control-register offsets (MASK/PEND/ID), `ctl_hit` decode function.
- Sub-module `irq_prio_enc`: sync stage(s), pend register, priority encoder producing `int_req`/`int_id`.

## Test plan
- Write 32'hDEAD_BEEF to 32'h7F14 (N_DEV=4, WIN_BITS=4) → `dev_sel`=4'b0010, `dev_addr`=1, `dev_we` one cycle at T+1, `pr_ready` at T+2, `pr_err`=0.
- Read 32'h7F30 with device 3 driving 32'h1234_5678, WAIT_CYC=2 → `dev_re` at T+1 only, `pr_rdata`=32'h1234_5678 with `pr_ready` at T+4.
- Read 32'h8000 (outside all windows) → no strobes, `pr_ready` at T+2, `pr_err`=1, `pr_rdata`=0.
- Write MASK=4'b1010 at 32'h7F40, raise `dev_irq`=4'b1110 → `int_req`=1, `int_id`=1; PEND read returns 32'hA.
- `pr_we`=`pr_re`=1 → miss response; then assert `rst` low during WAIT → strobes/`pr_ready`/`int_req` 0 same cycle, FSM IDLE after release.
